decode_execute_unit: RTL and testbench

DECODE_EXECUTE_UNIT -- requirements
Module: decode_execute_unit

---
 rtl/decode_execute_unit_pkg.sv | 78 +++++++
 rtl/decode_execute_unit_alu_core.sv | 79 +++++++
 rtl/decode_execute_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_decode_execute_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_execute_unit_pkg.sv
// Shared opcode/funct3 constants and the ALU-select and writeback-select
// encodings used by the decode/execute stage and its ALU.
package decode_execute_unit_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [31:0] INSN_NOP = 32'h00000013;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'd0;
    localparam logic [2:0] FUNCT3_SLL     = 3'd1;
    localparam logic [2:0] FUNCT3_SLT     = 3'd2;
    localparam logic [2:0] FUNCT3_SLTU    = 3'd3;
    localparam logic [2:0] FUNCT3_XOR     = 3'd4;
    localparam logic [2:0] FUNCT3_SR      = 3'd5;
    localparam logic [2:0] FUNCT3_OR      = 3'd6;
    localparam logic [2:0] FUNCT3_AND     = 3'd7;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;

    localparam logic [2:0] FUNCT3_BEQ  = 3'd0;
    localparam logic [2:0] FUNCT3_BNE  = 3'd1;
    localparam logic [2:0] FUNCT3_BLT  = 3'd4;
    localparam logic [2:0] FUNCT3_BGE  = 3'd5;
    localparam logic [2:0] FUNCT3_BLTU = 3'd6;
    localparam logic [2:0] FUNCT3_BGEU = 3'd7;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alusel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wbsel_e;

    // SUB exists only for register-register ops; ADDI ignores funct7[5].
    function automatic alusel_e arith_alusel(input logic [2:0] funct3,
                                             input logic       alt,
                                             input logic       allow_sub);
        alusel_e sel;
        sel = ALU_ADD;
        case (funct3)
            FUNCT3_ADD_SUB: sel = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            FUNCT3_SLL:     sel = ALU_SLL;
            FUNCT3_SLT:     sel = ALU_SLT;
            FUNCT3_SLTU:    sel = ALU_SLTU;
            FUNCT3_XOR:     sel = ALU_XOR;
            FUNCT3_SR:      sel = alt ? ALU_SRA : ALU_SRL;
            FUNCT3_OR:      sel = ALU_OR;
            FUNCT3_AND:     sel = ALU_AND;
            default:        sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/decode_execute_unit_alu_core.sv
// Combinational ALU plus branch comparator. The comparator looks at the raw
// register values because the adder is busy forming the branch target.
module alu_core
    import decode_execute_unit_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] op_a,
    input  logic [DWIDTH-1:0] op_b,
    input  alusel_e           alusel,
    input  logic [2:0]        funct3,
    input  logic              branch_en,
    input  logic [DWIDTH-1:0] cmp_a,
    input  logic [DWIDTH-1:0] cmp_b,
    output logic [DWIDTH-1:0] result,
    output logic              brtaken
);

    logic [DWIDTH-1:0] and_bits;
    logic [DWIDTH-1:0] or_bits;
    logic [DWIDTH-1:0] xor_bits;
    logic [4:0]        shamt;
    logic              lt_signed;
    logic              lt_unsigned;
    logic              cmp_eq;
    logic              cmp_lt_s;
    logic              cmp_lt_u;

    genvar gi;
    generate
        for (gi = 0; gi < DWIDTH; gi++) begin : g_bitwise
            assign and_bits[gi] = op_a[gi] & op_b[gi];
            assign or_bits[gi]  = op_a[gi] | op_b[gi];
            assign xor_bits[gi] = op_a[gi] ^ op_b[gi];
        end
    endgenerate

    assign shamt       = op_b[4:0];
    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;

    always_comb begin
        result = '0;
        case (alusel)
            ALU_ADD:    result = op_a + op_b;
            ALU_SUB:    result = op_a - op_b;
            ALU_SLL:    result = op_a << shamt;
            ALU_SLT:    result = {{(DWIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU:   result = {{(DWIDTH-1){1'b0}}, lt_unsigned};
            ALU_XOR:    result = xor_bits;
            ALU_SRL:    result = op_a >> shamt;
            ALU_SRA:    result = $signed(op_a) >>> shamt;
            ALU_OR:     result = or_bits;
            ALU_AND:    result = and_bits;
            ALU_PASS_B: result = op_b;
            default:    result = '0;
        endcase
    end

    assign cmp_eq   = cmp_a == cmp_b;
    assign cmp_lt_s = $signed(cmp_a) < $signed(cmp_b);
    assign cmp_lt_u = cmp_a < cmp_b;

    always_comb begin
        brtaken = 1'b0;
        if (branch_en) begin
            case (funct3)
                FUNCT3_BEQ:  brtaken = cmp_eq;
                FUNCT3_BNE:  brtaken = !cmp_eq;
                FUNCT3_BLT:  brtaken = cmp_lt_s;
                FUNCT3_BGE:  brtaken = !cmp_lt_s;
                FUNCT3_BLTU: brtaken = cmp_lt_u;
                FUNCT3_BGEU: brtaken = !cmp_lt_u;
                default:     brtaken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/decode_execute_unit.sv
// Decode/execute stage: registers the fetched instruction and PC, decodes
// fields, immediate and control, and evaluates the ALU in the same cycle.
module decode_execute_unit
    import decode_execute_unit_pkg::*;
#(
    parameter int              AWIDTH   = 32,
    parameter int              DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] rs1data_i,
    input  logic [DWIDTH-1:0] rs2data_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [31:0]       imm_o,
    output logic [4:0]        shamt_o,
    output logic              pcsel_o,
    output logic              immsel_o,
    output logic              regwren_o,
    output logic              rs1sel_o,
    output logic              rs2sel_o,
    output logic              memren_o,
    output logic              memwren_o,
    output logic [1:0]        wbsel_o,
    output logic [3:0]        alusel_o,
    output logic [DWIDTH-1:0] alu_res_o,
    output logic              brtaken_o
);

    logic [DWIDTH-1:0] insn_reg;
    logic [AWIDTH-1:0] pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            insn_reg <= DWIDTH'(INSN_NOP);
            pc_reg   <= BASEADDR;
        end else begin
            insn_reg <= insn_i;
            pc_reg   <= pc_i;
        end
    end

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i_fmt;
    logic [31:0] imm_s_fmt;
    logic [31:0] imm_b_fmt;
    logic [31:0] imm_u_fmt;
    logic [31:0] imm_j_fmt;

    assign opcode = insn_reg[6:0];
    assign funct3 = insn_reg[14:12];
    assign funct7 = insn_reg[31:25];

    assign imm_i_fmt = {{20{insn_reg[31]}}, insn_reg[31:20]};
    assign imm_s_fmt = {{20{insn_reg[31]}}, insn_reg[31:25], insn_reg[11:7]};
    assign imm_b_fmt = {{19{insn_reg[31]}}, insn_reg[31], insn_reg[7],
                        insn_reg[30:25], insn_reg[11:8], 1'b0};
    assign imm_u_fmt = {insn_reg[31:12], 12'b0};
    assign imm_j_fmt = {{11{insn_reg[31]}}, insn_reg[31], insn_reg[19:12],
                        insn_reg[20], insn_reg[30:21], 1'b0};

    logic [31:0] imm_val;
    logic        pcsel;
    logic        b_is_imm;
    logic        regwren;
    logic        a_is_pc;
    logic        memren;
    logic        memwren;
    wbsel_e      wbsel;
    alusel_e     alusel;
    logic        op_valid;
    logic        is_branch;
    logic        is_jalr;

    always_comb begin
        imm_val   = '0;
        pcsel     = 1'b0;
        b_is_imm  = 1'b0;
        regwren   = 1'b0;
        a_is_pc   = 1'b0;
        memren    = 1'b0;
        memwren   = 1'b0;
        wbsel     = WB_ALU;
        alusel    = ALU_ADD;
        op_valid  = 1'b0;
        is_branch = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OPC_OP: begin
                op_valid = 1'b1;
                regwren  = 1'b1;
                alusel   = arith_alusel(funct3, funct7[5], 1'b1);
            end
            OPC_OP_IMM: begin
                op_valid = 1'b1;
                regwren  = 1'b1;
                b_is_imm = 1'b1;
                imm_val  = imm_i_fmt;
                alusel   = arith_alusel(funct3, funct7[5], 1'b0);
            end
            OPC_LOAD: begin
                op_valid = 1'b1;
                memren   = 1'b1;
                regwren  = 1'b1;
                b_is_imm = 1'b1;
                imm_val  = imm_i_fmt;
                wbsel    = WB_MEM;
            end
            OPC_STORE: begin
                op_valid = 1'b1;
                memwren  = 1'b1;
                b_is_imm = 1'b1;
                imm_val  = imm_s_fmt;
            end
            OPC_BRANCH: begin
                op_valid  = 1'b1;
                is_branch = 1'b1;
                a_is_pc   = 1'b1;
                b_is_imm  = 1'b1;
                imm_val   = imm_b_fmt;
            end
            OPC_JAL: begin
                op_valid = 1'b1;
                pcsel    = 1'b1;
                regwren  = 1'b1;
                a_is_pc  = 1'b1;
                b_is_imm = 1'b1;
                imm_val  = imm_j_fmt;
                wbsel    = WB_PC4;
            end
            OPC_JALR: begin
                op_valid = 1'b1;
                is_jalr  = 1'b1;
                pcsel    = 1'b1;
                regwren  = 1'b1;
                b_is_imm = 1'b1;
                imm_val  = imm_i_fmt;
                wbsel    = WB_PC4;
            end
            OPC_LUI: begin
                op_valid = 1'b1;
                regwren  = 1'b1;
                b_is_imm = 1'b1;
                imm_val  = imm_u_fmt;
                alusel   = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                op_valid = 1'b1;
                regwren  = 1'b1;
                a_is_pc  = 1'b1;
                b_is_imm = 1'b1;
                imm_val  = imm_u_fmt;
            end
            default: ;
        endcase
    end

    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] op_b;
    logic [DWIDTH-1:0] alu_result;
    logic              alu_brtaken;

    assign op_a = a_is_pc ? DWIDTH'(pc_reg) : rs1data_i;
    assign op_b = b_is_imm ? DWIDTH'(imm_val) : rs2data_i;

    alu_core #(
        .DWIDTH (DWIDTH)
    ) u_alu_core (
        .op_a      (op_a),
        .op_b      (op_b),
        .alusel    (alusel),
        .funct3    (funct3),
        .branch_en (is_branch),
        .cmp_a     (rs1data_i),
        .cmp_b     (rs2data_i),
        .result    (alu_result),
        .brtaken   (alu_brtaken)
    );

    assign pc_o     = pc_reg;
    assign insn_o   = insn_reg;
    assign opcode_o = opcode;
    assign rd_o     = insn_reg[11:7];
    assign rs1_o    = insn_reg[19:15];
    assign rs2_o    = insn_reg[24:20];
    assign funct3_o = funct3;
    assign funct7_o = funct7;
    assign shamt_o  = insn_reg[24:20];
    assign imm_o    = imm_val;

    assign pcsel_o   = pcsel;
    assign immsel_o  = b_is_imm;
    assign rs2sel_o  = b_is_imm;
    assign regwren_o = regwren;
    assign rs1sel_o  = a_is_pc;
    assign memren_o  = memren;
    assign memwren_o = memwren;
    assign wbsel_o   = wbsel;
    assign alusel_o  = alusel;

    // JALR targets are halfword-aligned by dropping bit 0 of the sum.
    always_comb begin
        alu_res_o = '0;
        if (op_valid)
            alu_res_o = is_jalr ? {alu_result[DWIDTH-1:1], 1'b0} : alu_result;
    end

    assign brtaken_o = alu_brtaken;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Scoreboard bench: a driver issues directed then random instructions and
// queues the expected stage outputs; a monitor pops and compares them.
module tb_decode_execute_unit;

    localparam logic [31:0] BASE = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] insn_i, pc_i, rs1data_i, rs2data_i;
    logic [31:0] pc_o, insn_o, imm_o, alu_res_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
    logic [2:0]  funct3_o;
    logic        pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o;
    logic        memren_o, memwren_o, brtaken_o;
    logic [1:0]  wbsel_o;
    logic [3:0]  alusel_o;

    always #5 clk = ~clk;

    decode_execute_unit #(
        .AWIDTH(32), .DWIDTH(32), .BASEADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .insn_i(insn_i), .pc_i(pc_i),
        .rs1data_i(rs1data_i), .rs2data_i(rs2data_i),
        .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .imm_o(imm_o), .shamt_o(shamt_o), .pcsel_o(pcsel_o), .immsel_o(immsel_o),
        .regwren_o(regwren_o), .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o),
        .memren_o(memren_o), .memwren_o(memwren_o), .wbsel_o(wbsel_o),
        .alusel_o(alusel_o), .alu_res_o(alu_res_o), .brtaken_o(brtaken_o)
    );

    typedef struct {
        bit          rst;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } stim_t;

    // ctl packs {pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren}
    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] imm;
        logic [6:0]  ctl;
        logic [1:0]  wbsel;
        logic [3:0]  alusel;
        logic [31:0] res;
        logic        br;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   issued = 0;
    bit   valid_pipe = 0;
    int   cur_id = 0;

    // Register-register and register-immediate arithmetic, by instruction meaning.
    function automatic void arith(input logic [2:0] f3, input bit alt, input bit is_r,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] sel);
        case (f3)
            3'd0: if (is_r && alt) begin r = x - y; sel = 4'd1; end
                  else begin r = x + y; sel = 4'd0; end
            3'd1: begin r = x << y[4:0]; sel = 4'd2; end
            3'd2: begin r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; sel = 4'd3; end
            3'd3: begin r = (x < y) ? 32'd1 : 32'd0; sel = 4'd4; end
            3'd4: begin r = x ^ y; sel = 4'd5; end
            3'd5: if (alt) begin r = $signed(x) >>> y[4:0]; sel = 4'd7; end
                  else begin r = x >> y[4:0]; sel = 4'd6; end
            3'd6: begin r = x | y; sel = 4'd8; end
            default: begin r = x & y; sel = 4'd9; end
        endcase
    endfunction

    function automatic exp_t model(input stim_t s, input int id);
        exp_t e;
        logic [31:0] w, i_imm, s_imm, b_imm, u_imm, j_imm, a, b;
        logic signed [31:0] sa, sb_v;
        w = s.rst ? 32'h00000013 : s.insn;
        e.id = id; e.pc = s.rst ? BASE : s.pc; e.insn = w;
        e.imm = 0; e.ctl = 0; e.wbsel = 0; e.alusel = 0; e.res = 0; e.br = 0;
        a = s.rs1; b = s.rs2; sa = s.rs1; sb_v = s.rs2;
        i_imm = {{20{w[31]}}, w[31:20]};
        s_imm = {{20{w[31]}}, w[31:25], w[11:7]};
        b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        u_imm = {w[31:12], 12'h000};
        j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'h33: begin e.ctl = 7'b0010000; arith(w[14:12], w[30], 1, a, b, e.res, e.alusel); end
            7'h13: begin e.ctl = 7'b0110100; e.imm = i_imm;
                         arith(w[14:12], w[30], 0, a, i_imm, e.res, e.alusel); end
            7'h03: begin e.ctl = 7'b0110110; e.imm = i_imm; e.wbsel = 1; e.res = a + i_imm; end
            7'h23: begin e.ctl = 7'b0100101; e.imm = s_imm; e.res = a + s_imm; end
            7'h63: begin
                e.ctl = 7'b0101100; e.imm = b_imm; e.res = e.pc + b_imm;
                case (w[14:12])
                    3'd0: e.br = (a == b);
                    3'd1: e.br = (a != b);
                    3'd4: e.br = (sa < sb_v);
                    3'd5: e.br = (sa >= sb_v);
                    3'd6: e.br = (a < b);
                    3'd7: e.br = (a >= b);
                    default: e.br = 0;
                endcase
            end
            7'h6F: begin e.ctl = 7'b1111100; e.imm = j_imm; e.wbsel = 2; e.res = e.pc + j_imm; end
            7'h67: begin e.ctl = 7'b1110100; e.imm = i_imm; e.wbsel = 2;
                         e.res = (a + i_imm) & 32'hFFFF_FFFE; end
            7'h37: begin e.ctl = 7'b0110100; e.imm = u_imm; e.alusel = 10; e.res = u_imm; end
            7'h17: begin e.ctl = 7'b0111100; e.imm = u_imm; e.res = e.pc + u_imm; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL txn %0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    always @(posedge clk) valid_pipe <= issued;

    always @(negedge clk) begin
        if (valid_pipe) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL output with empty scoreboard: got data expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pc", e.id, pc_o, e.pc);
                chk("insn", e.id, insn_o, e.insn);
                chk("opcode", e.id, 32'(opcode_o), 32'(e.insn[6:0]));
                chk("rd", e.id, 32'(rd_o), 32'(e.insn[11:7]));
                chk("rs1", e.id, 32'(rs1_o), 32'(e.insn[19:15]));
                chk("rs2", e.id, 32'(rs2_o), 32'(e.insn[24:20]));
                chk("funct3", e.id, 32'(funct3_o), 32'(e.insn[14:12]));
                chk("funct7", e.id, 32'(funct7_o), 32'(e.insn[31:25]));
                chk("shamt", e.id, 32'(shamt_o), 32'(e.insn[24:20]));
                chk("imm", e.id, imm_o, e.imm);
                chk("ctl", e.id, 32'({pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o,
                                      memren_o, memwren_o}), 32'(e.ctl));
                chk("wbsel", e.id, 32'(wbsel_o), 32'(e.wbsel));
                chk("alusel", e.id, 32'(alusel_o), 32'(e.alusel));
                chk("alu_res", e.id, alu_res_o, e.res);
                chk("brtaken", e.id, 32'(brtaken_o), 32'(e.br));
                $display("txn %0d insn=%h pc=%h res=%h br=%0d", e.id, insn_o, pc_o,
                         alu_res_o, brtaken_o);
            end
        end
    end

    logic [31:0] nxt_rs1 = 0;
    logic [31:0] nxt_rs2 = 0;

    task automatic issue(input stim_t s);
        @(posedge clk);
        #1;
        rs1data_i = nxt_rs1;
        rs2data_i = nxt_rs2;
        rst       = s.rst;
        insn_i    = s.insn;
        pc_i      = s.pc;
        issued    = 1;
        nxt_rs1   = s.rs1;
        nxt_rs2   = s.rs2;
        sb.push_back(model(s, cur_id));
        cur_id++;
    endtask

    function automatic stim_t mk(input bit r, input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
        stim_t s;
        s.rst = r; s.insn = i; s.pc = p; s.rs1 = a; s.rs2 = b;
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t dir[$];
        logic [6:0] ops [10];
        ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        rst = 1; insn_i = 0; pc_i = 0; rs1data_i = 0; rs2data_i = 0;

        dir.push_back(mk(1, 32'h00000073, 32'h0, 32'h0, 32'h0));
        dir.push_back(mk(0, 32'h00000073, 32'h01000004, 32'h55, 32'h66));
        dir.push_back(mk(0, 32'h00500093, 32'h01000008, 32'h0, 32'h0));
        dir.push_back(mk(0, 32'h40208033, 32'h0100000C, 32'd10, 32'd3));
        dir.push_back(mk(0, 32'h00208463, 32'h01000010, 32'd4, 32'd4));
        dir.push_back(mk(0, 32'h00208463, 32'h01000010, 32'd4, 32'd5));
        dir.push_back(mk(0, 32'h4040D093, 32'h01000014, 32'h80000000, 32'h0));
        dir.push_back(mk(0, 32'h00008067, 32'h01000018, 32'h01000101, 32'h0));
        dir.push_back(mk(0, 32'h123452B7, 32'h0100001C, 32'h0, 32'h0));
        dir.push_back(mk(1, 32'h00208463, 32'h01000020, 32'd7, 32'd7));
        dir.push_back(mk(0, 32'h0020A463, 32'h01000024, 32'd1, 32'd1));
        foreach (dir[k]) issue(dir[k]);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w, a, b;
            logic [6:0]  op;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            w  = {$urandom(), 7'h00} | 32'(op);
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
            issue(mk($urandom_range(0, 49) == 0, w, $urandom(), a, b));
        end

        @(posedge clk);
        #1;
        rs1data_i = nxt_rs1;
        rs2data_i = nxt_rs2;
        issued    = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
